// File: rtl/la_mux_defs.sv
// Shared arbitration mode encodings for the lambdalib mux family.
package la_mux_defs;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/la_rrarb.sv
// Combinational arbiter: fixed priority (index 0 first) or round-robin from ptr.
// Zero latency; grant is one-hot or zero and only ever selects a requesting channel.
module la_rrarb
  import la_mux_defs::*;
#(
  parameter int N   = 4,
  parameter int ARB = ARB_RR,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] index
);

  localparam logic [PW:0] NL = N[PW:0];

  logic [PW-1:0] base;
  logic [PW:0]   sum;
  logic          found;

  assign base = (ARB == ARB_RR) ? ptr : '0;

  // Walk channels starting at base, wrapping modulo N; the first requester wins.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, base} + k[PW:0];
      if (sum >= NL) sum = sum - NL;
      if (!found && req[sum[PW-1:0]]) begin
        found             = 1'b1;
        index             = sum[PW-1:0];
        grant[sum[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/la_rrmux.sv
// N:1 arbitrated mux with a single output register; latency 1 cycle, full throughput.
// Backpressure: in_ready drops to zero while the output register is held by out_ready=0.
module la_rrmux
  import la_mux_defs::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int ARB  = ARB_RR,
  parameter     PROP = "DEFAULT"
) (
  input  logic           clk,
  input  logic           nreset,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_grant,
  input  logic           out_ready
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [PW-1:0] ptr;
  logic [N-1:0]  grant;
  logic [PW-1:0] index;
  logic          load;
  logic          take;
  logic [PW-1:0] ptr_nxt;

  la_rrarb #(.N(N), .ARB(ARB)) u_arb (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (grant),
    .index (index)
  );

  // Gating with nreset keeps in_ready low while reset is held, even though
  // the cleared output register would otherwise look ready to load.
  assign load     = ~out_valid | out_ready;
  assign in_ready = grant & {N{load & nreset}};
  assign take     = |in_ready;
  assign ptr_nxt  = (index == LAST) ? '0 : index + 1'b1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      ptr       <= '0;
    end else begin
      if (load) out_valid <= take;
      if (take) begin
        out_data  <= in_data[index*W +: W];
        out_grant <= grant;
        if (ARB == ARB_RR) ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_la_rrmux.sv
// Directed bench for la_rrmux: round-robin and fixed-priority instances share stimulus.
module tb_la_rrmux;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           nreset;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0]   rr_in_ready, fx_in_ready;
  logic           rr_out_valid, fx_out_valid;
  logic [W-1:0]   rr_out_data, fx_out_data;
  logic [N-1:0]   rr_out_grant, fx_out_grant;

  int n_cmp = 0;
  int n_bad = 0;

  la_rrmux #(.N(N), .W(W), .ARB(1)) u_rr (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_grant (rr_out_grant),
    .out_ready (out_ready)
  );

  la_rrmux #(.N(N), .W(W), .ARB(0)) u_fx (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (fx_in_ready),
    .out_valid (fx_out_valid),
    .out_data  (fx_out_data),
    .out_grant (fx_out_grant),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset    = 1'b0;
    in_valid  = 4'b1111;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", {28'd0, rr_in_ready}, 32'h0);
    tick();
    tick();
    check_eq("rst_out_valid", {31'd0, rr_out_valid}, 32'h0);
    check_eq("rst_in_ready_held", {28'd0, rr_in_ready}, 32'h0);

    // Release reset while idle
    in_valid = 4'b0000;
    @(negedge clk);
    nreset = 1'b1;
    tick();
    check_eq("idle_out_valid", {31'd0, rr_out_valid}, 32'h0);
    check_eq("idle_in_ready", {28'd0, rr_in_ready}, 32'h0);
    check_eq("idle_out_data", {24'd0, rr_out_data}, 32'h0);
    check_eq("idle_ptr", {30'd0, u_rr.ptr}, 32'h0);

    // All channels requesting, downstream always ready
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("rr_grant_%0d", k), {28'd0, rr_out_grant}, 32'(1 << (k % 4)));
      check_eq($sformatf("rr_data_%0d", k), {24'd0, rr_out_data}, 32'h10 + 32'(k % 4));
      check_eq($sformatf("rr_valid_%0d", k), {31'd0, rr_out_valid}, 32'h1);
      check_eq($sformatf("fx_grant_%0d", k), {28'd0, fx_out_grant}, 32'h1);
      check_eq($sformatf("fx_data_%0d", k), {24'd0, fx_out_data}, 32'h10);
    end
    check_eq("rr_ptr_after5", {30'd0, u_rr.ptr}, 32'h1);

    // Requests drop: output drains, nothing latched
    in_valid = 4'b0000;
    tick();
    check_eq("drain_out_valid", {31'd0, rr_out_valid}, 32'h0);
    check_eq("drain_ptr", {30'd0, u_rr.ptr}, 32'h1);

    // Backpressure: capture ch2, then stall three cycles
    in_data   = {8'h33, 8'hA5, 8'h11, 8'h0F};
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    tick();
    check_eq("bp_load_data", {24'd0, rr_out_data}, 32'hA5);
    check_eq("bp_load_grant", {28'd0, rr_out_grant}, 32'h4);
    in_valid = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("bp_hold_data_%0d", k), {24'd0, rr_out_data}, 32'hA5);
      check_eq($sformatf("bp_hold_grant_%0d", k), {28'd0, rr_out_grant}, 32'h4);
      check_eq($sformatf("bp_in_ready_%0d", k), {28'd0, rr_in_ready}, 32'h0);
      check_eq($sformatf("bp_valid_%0d", k), {31'd0, rr_out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    tick();
    check_eq("bp_release_grant", {28'd0, rr_out_grant}, 32'h8);
    check_eq("bp_release_data", {24'd0, rr_out_data}, 32'h33);
    check_eq("bp_release_ptr", {30'd0, u_rr.ptr}, 32'h0);

    // Wrap: bring ptr to 3, then requests on ch0 and ch3
    in_valid = 4'b0100;
    tick();
    check_eq("wrap_setup_ptr", {30'd0, u_rr.ptr}, 32'h3);
    in_valid = 4'b1001;
    tick();
    check_eq("wrap_grant_a", {28'd0, rr_out_grant}, 32'h8);
    check_eq("wrap_ptr_a", {30'd0, u_rr.ptr}, 32'h0);
    tick();
    check_eq("wrap_grant_b", {28'd0, rr_out_grant}, 32'h1);
    check_eq("wrap_data_b", {24'd0, rr_out_data}, 32'h0F);
    check_eq("wrap_ptr_b", {30'd0, u_rr.ptr}, 32'h1);

    // Reset asserted mid-stall clears state without a clock edge
    in_valid = 4'b0010;
    tick();
    check_eq("mid_load_grant", {28'd0, rr_out_grant}, 32'h2);
    out_ready = 1'b0;
    tick();
    check_eq("mid_stall_valid", {31'd0, rr_out_valid}, 32'h1);
    check_eq("mid_stall_ptr", {30'd0, u_rr.ptr}, 32'h2);
    #2;
    nreset = 1'b0;
    #1;
    check_eq("arst_out_valid", {31'd0, rr_out_valid}, 32'h0);
    check_eq("arst_ptr", {30'd0, u_rr.ptr}, 32'h0);
    check_eq("arst_grant", {28'd0, rr_out_grant}, 32'h0);
    check_eq("arst_data", {24'd0, rr_out_data}, 32'h0);
    check_eq("arst_in_ready", {28'd0, rr_in_ready}, 32'h0);

    in_valid = 4'b0000;
    @(negedge clk);
    nreset = 1'b1;
    tick();
    check_eq("post_rst_valid", {31'd0, rr_out_valid}, 32'h0);
    check_eq("post_rst_in_ready", {28'd0, rr_in_ready}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
